// File: rtl/program_loader_if.sv
// Byte-stream and program-memory write bundle for program_loader.
// Handshake: a byte transfers on a rising clk edge where in_valid && in_ready;
// the sender holds in_data stable while in_valid is high and in_ready is low.
interface program_loader_if #(
  parameter int ADDR_W = 8
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              pm_we;
  logic [ADDR_W-1:0] pm_addr;
  logic [31:0]       pm_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;
  logic [2:0]        state_dbg;

  // Byte source / observer side.
  modport master (
    output in_data, in_valid,
    input  in_ready, pm_we, pm_addr, pm_wdata, cpu_hold, load_done, load_err, state_dbg
  );

  // Loader side.
  modport slave (
    input  in_data, in_valid,
    output in_ready, pm_we, pm_addr, pm_wdata, cpu_hold, load_done, load_err, state_dbg
  );
endinterface

// File: rtl/program_loader.sv
// Assembles a framed byte stream (MAGIC, LEN_LO, LEN_HI, LEN little-endian
// words, CHK) into 32-bit program-memory writes and holds the core in reset
// until a complete image with a matching XOR checksum has been loaded.
module program_loader #(
  parameter int          ADDR_W = 8,
  parameter logic [7:0]  MAGIC  = 8'hA5
) (
  input  logic           clk,
  input  logic           reset_n,
  program_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN0 = 3'd1,
    S_LEN1 = 3'd2,
    S_DATA = 3'd3,
    S_CHK  = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  // Largest legal word count: the whole memory.
  localparam logic [16:0] MAX_LEN = 17'd1 << ADDR_W;

  state_t            r_state;
  logic [7:0]        r_len_lo;
  logic [15:0]       r_len;
  logic [1:0]        r_byte_idx;
  logic [23:0]       r_word;      // low three bytes of the word in progress
  logic [7:0]        r_chk;
  logic              r_pm_we;
  logic [ADDR_W-1:0] r_pm_addr;
  logic [31:0]       r_pm_wdata;
  logic              r_cpu_hold;
  logic              r_load_done;
  logic              r_load_err;

  logic              w_fire;
  logic              w_magic;
  logic [15:0]       w_len;
  logic              w_last;

  // The write cycle is the only cycle that refuses a byte.
  assign w_fire  = bus.in_valid & ~r_pm_we;
  assign w_magic = (bus.in_data == MAGIC);
  assign w_len   = {bus.in_data, r_len_lo};
  // True when the word being written is word LEN-1.
  assign w_last  = ((17'(r_pm_addr) + 17'd1) == {1'b0, r_len});

  // Frame FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_len_lo    <= '0;
      r_len       <= '0;
      r_byte_idx  <= '0;
      r_word      <= '0;
      r_chk       <= '0;
      r_pm_we     <= 1'b0;
      r_pm_addr   <= '0;
      r_pm_wdata  <= '0;
      r_cpu_hold  <= 1'b1;
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
    end else if (r_pm_we) begin
      // Write cycle: advance the address unless this was the final word.
      r_pm_we <= 1'b0;
      if (w_last) r_state   <= S_CHK;
      else        r_pm_addr <= r_pm_addr + 1'b1;
    end else if (w_fire) begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (w_magic) begin
            r_state     <= S_LEN0;
            r_chk       <= '0;
            r_byte_idx  <= '0;
            r_pm_addr   <= '0;
            r_cpu_hold  <= 1'b1;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
          end
        end
        S_LEN0: begin
          r_len_lo <= bus.in_data;
          r_state  <= S_LEN1;
        end
        S_LEN1: begin
          r_len <= w_len;
          if ({1'b0, w_len} > MAX_LEN) begin
            r_state     <= S_ERR;
            r_cpu_hold  <= 1'b1;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b1;
          end else if (w_len == 16'd0) begin
            r_state <= S_CHK;
          end else begin
            r_state   <= S_DATA;
            r_pm_addr <= '0;
            r_chk     <= '0;
          end
        end
        S_DATA: begin
          r_chk      <= r_chk ^ bus.in_data;
          r_byte_idx <= r_byte_idx + 2'd1;
          r_word     <= {bus.in_data, r_word[23:8]};
          if (r_byte_idx == 2'd3) begin
            r_pm_wdata <= {bus.in_data, r_word};
            r_pm_we    <= 1'b1;
          end
        end
        S_CHK: begin
          if (bus.in_data == r_chk) begin
            r_state     <= S_DONE;
            r_cpu_hold  <= 1'b0;
            r_load_done <= 1'b1;
            r_load_err  <= 1'b0;
          end else begin
            r_state     <= S_ERR;
            r_cpu_hold  <= 1'b1;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = ~r_pm_we;
  assign bus.pm_we     = r_pm_we;
  assign bus.pm_addr   = r_pm_addr;
  assign bus.pm_wdata  = r_pm_wdata;
  assign bus.cpu_hold  = r_cpu_hold;
  assign bus.load_done = r_load_done;
  assign bus.load_err  = r_load_err;
  assign bus.state_dbg = r_state;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: frames are driven byte by byte, every
// expected memory write is queued before its bytes are sent and popped by a
// write monitor, status levels are checked after each frame.
module tb_program_loader;
  localparam int ADDR_W = 8;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  logic [ADDR_W+31:0] exp_q[$];
  logic [31:0]        wbuf[0:255];

  program_loader_if #(.ADDR_W(ADDR_W)) bus ();

  program_loader #(.ADDR_W(ADDR_W), .MAGIC(8'hA5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Clock and global time limit.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Write monitor: each pm_we cycle must match the head of the expected queue.
  always @(negedge clk) begin
    if (reset_n && bus.pm_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", {bus.pm_addr, bus.pm_wdata}, 64'hDEAD);
      end else begin
        check("we_word", {bus.pm_addr, bus.pm_wdata}, exp_q.pop_front());
        check("we_ready_low", bus.in_ready, 1'b0);
      end
    end
  end

  // Drive one byte after 'gap' idle cycles; returns #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    repeat (gap) @(posedge clk);
    #1;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom_range(0, 255));
  endtask

  // Full frame from wbuf[0..n-1]; gap_max > 0 inserts random idle cycles.
  task automatic send_frame(input logic [15:0] len, input int n, input logic [7:0] chk,
                            input int gap_max);
    logic [31:0] w;
    send_byte(8'hA5, 0);
    check("hold_in_frame", bus.cpu_hold, 1'b1);
    check("done_clr_in_frame", bus.load_done, 1'b0);
    check("err_clr_in_frame", bus.load_err, 1'b0);
    send_byte(len[7:0], 0);
    send_byte(len[15:8], 0);
    for (int i = 0; i < n; i++) begin
      w = wbuf[i];
      exp_q.push_back({8'(i), w});
      for (int k = 0; k < 4; k++) begin
        send_byte(w[8*k +: 8], $urandom_range(0, gap_max));
      end
    end
    send_byte(chk, $urandom_range(0, gap_max));
    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic expect_status(input string tag, input logic hold, input logic done,
                               input logic err);
    check({tag, "_hold"}, bus.cpu_hold, hold);
    check({tag, "_done"}, bus.load_done, done);
    check({tag, "_err"}, bus.load_err, err);
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    reset_n      = 1'b0;

    // Reset then idle.
    repeat (3) @(posedge clk);
    @(negedge clk);
    expect_status("reset", 1'b1, 1'b0, 1'b0);
    check("reset_we", bus.pm_we, 1'b0);
    check("reset_ready", bus.in_ready, 1'b1);
    check("reset_addr", bus.pm_addr, 0);
    check("reset_wdata", bus.pm_wdata, 0);
    reset_n = 1'b1;

    // Leading junk then a valid 2-word image; XOR of word bytes is 8'h30.
    send_byte(8'h00, 1);
    send_byte(8'hFF, 0);
    expect_status("junk", 1'b1, 1'b0, 1'b0);
    check("junk_state", bus.state_dbg, 3'd0);
    wbuf[0] = 32'h00A00513;
    wbuf[1] = 32'h00100593;
    send_frame(16'd2, 2, 8'h30, 0);
    expect_status("valid", 1'b0, 1'b1, 1'b0);

    // Bad checksum: writes still happen, core stays held.
    send_frame(16'd2, 2, 8'h31, 0);
    expect_status("badchk", 1'b1, 1'b0, 1'b1);

    // Recovery with a good frame.
    send_frame(16'd2, 2, 8'h30, 0);
    expect_status("recover", 1'b0, 1'b1, 1'b0);

    // LEN = 0x0101 exceeds memory depth: error straight from the header.
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    expect_status("toolong", 1'b1, 1'b0, 1'b1);

    // LEN = 0 with CHK = 00: done without writes.
    send_frame(16'd0, 0, 8'h00, 0);
    expect_status("len0", 1'b0, 1'b1, 1'b0);

    // Random stalls between bytes.
    send_frame(16'd2, 2, 8'h30, 3);
    expect_status("stall", 1'b0, 1'b1, 1'b0);

    // Reset after the 6th word byte: only word 0 is written.
    send_byte(8'hA5, 0);
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    exp_q.push_back({8'd0, 32'h00A00513});
    send_byte(8'h13, 0);
    send_byte(8'h05, 0);
    send_byte(8'hA0, 0);
    send_byte(8'h00, 0);
    send_byte(8'h93, 0);
    send_byte(8'h05, 0);
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_we", bus.pm_we, 1'b0);
    check("midrst_addr", bus.pm_addr, 0);
    expect_status("midrst", 1'b1, 1'b0, 1'b0);
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("midrst_no_more_we", exp_q.size(), 0);
    send_frame(16'd2, 2, 8'h30, 0);
    expect_status("reload", 1'b0, 1'b1, 1'b0);

    // Full-depth image: 256 words, last write at 255, no wrap.
    // Word i = {i, ~i, 5A, i}; every byte column XORs to zero over 256 words.
    for (int i = 0; i < 256; i++) begin
      logic [7:0] ib;
      ib = 8'(i);
      wbuf[i] = {ib, ~ib, 8'h5A, ib};
    end
    send_frame(16'h0100, 256, 8'h00, 0);
    expect_status("full", 1'b0, 1'b1, 1'b0);
    check("full_last_addr", bus.pm_addr, 8'hFF);

    check("final_queue", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
